// File: rtl/cpu_commit_stage_if.sv
// Execute-to-commit, commit-to-memory and commit-to-writeback/forwarding signal bundle.
// master = environment side (execute, data memory), slave = the commit stage itself.
interface cpu_commit_stage_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5
);
  logic                    in_valid;
  logic [31:0]             in_alu_result;
  logic [31:0]             in_rb_data;
  logic [REG_ID_WIDTH-1:0] in_reg_dest;
  logic                    in_reg_write;
  logic                    in_mem_read;
  logic                    in_mem_write;
  logic                    in_mem_byte;
  logic                    stall_out;

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_be;
  logic                    mem_ack;
  logic [31:0]             mem_rdata;

  logic                    wb_valid;
  logic [REG_ID_WIDTH-1:0] wb_reg_dest;
  logic                    wb_reg_write;
  logic [31:0]             wb_value;
  logic [31:0]             fw_commit_value;
  logic [REG_ID_WIDTH-1:0] fw_commit_rd;
  logic                    fw_commit_wb;
  logic                    misalign;

  modport master (
    output in_valid, in_alu_result, in_rb_data, in_reg_dest, in_reg_write,
           in_mem_read, in_mem_write, in_mem_byte, mem_ack, mem_rdata,
    input  stall_out, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_reg_dest, wb_reg_write, wb_value,
           fw_commit_value, fw_commit_rd, fw_commit_wb, misalign
  );

  modport slave (
    input  in_valid, in_alu_result, in_rb_data, in_reg_dest, in_reg_write,
           in_mem_read, in_mem_write, in_mem_byte, mem_ack, mem_rdata,
    output stall_out, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_reg_dest, wb_reg_write, wb_value,
           fw_commit_value, fw_commit_rd, fw_commit_wb, misalign
  );
endinterface

// File: rtl/cpu_commit_stage.sv
// Commit stage: ALU results pass to writeback in 1 cycle; loads/stores go through a req/ack
// access (>=2 cycles to writeback) while stall_out holds the upstream pipeline.
module cpu_commit_stage #(
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_ID_WIDTH = 5
) (
  input logic               clock,
  input logic               reset,
  cpu_commit_stage_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic [3:0]              r_be;
  logic                    r_we;
  logic                    r_byte;
  logic                    r_reg_write;
  logic [REG_ID_WIDTH-1:0] r_dest;
  logic                    r_misalign;

  logic                    r_wb_valid;
  logic                    r_wb_write;
  logic [31:0]             r_wb_value;
  logic [REG_ID_WIDTH-1:0] r_wb_dest;

  logic                    w_accept;
  logic                    w_is_mem;
  logic                    w_ack;
  logic [7:0]              w_lane;
  logic [31:0]             w_load;

  assign w_accept = bus.in_valid & (r_state == IDLE);
  assign w_is_mem = bus.in_mem_read | bus.in_mem_write;
  // Ack only counts while a request is actually on the bus.
  assign w_ack    = (r_state == WAIT) & bus.mem_ack;
  assign w_lane   = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_load   = r_byte ? {24'h0, w_lane} : bus.mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_mem) w_state_nxt = WAIT;
      WAIT:    if (bus.mem_ack)          w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_reg_write <= 1'b0;
      r_dest      <= '0;
      r_misalign  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_write  <= 1'b0;
      r_wb_value  <= '0;
      r_wb_dest   <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      if (w_accept) begin
        if (w_is_mem) begin
          r_addr      <= bus.in_alu_result;
          r_we        <= bus.in_mem_write;
          r_byte      <= bus.in_mem_byte;
          r_reg_write <= bus.in_reg_write;
          r_dest      <= bus.in_reg_dest;
          r_be        <= bus.in_mem_byte ? (4'b0001 << bus.in_alu_result[1:0]) : 4'b1111;
          r_wdata     <= bus.in_mem_byte ? {4{bus.in_rb_data[7:0]}} : bus.in_rb_data;
          r_misalign  <= ~bus.in_mem_byte & (|bus.in_alu_result[1:0]);
        end else begin
          r_wb_valid <= 1'b1;
          r_wb_value <= bus.in_alu_result;
          r_wb_dest  <= bus.in_reg_dest;
          r_wb_write <= bus.in_reg_write;
        end
      end
      // Stores report their address and never write the register file.
      if (w_ack) begin
        r_wb_valid <= 1'b1;
        r_wb_dest  <= r_dest;
        r_wb_write <= r_we ? 1'b0 : r_reg_write;
        r_wb_value <= r_we ? r_addr : w_load;
      end
    end
  end

  assign bus.stall_out       = (r_state == WAIT);
  assign bus.mem_req         = (r_state == WAIT);
  assign bus.mem_we          = (r_state == WAIT) & r_we;
  assign bus.mem_be          = (r_state == WAIT) ? r_be : 4'b0000;
  assign bus.mem_addr        = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata       = r_wdata;
  assign bus.wb_valid        = r_wb_valid;
  assign bus.wb_reg_dest     = r_wb_dest;
  assign bus.wb_reg_write    = r_wb_write;
  assign bus.wb_value        = r_wb_value;
  assign bus.fw_commit_value = r_wb_value;
  assign bus.fw_commit_rd    = r_wb_dest;
  assign bus.fw_commit_wb    = r_wb_valid & r_wb_write;
  assign bus.misalign        = r_misalign;
endmodule

// File: tb/tb_cpu_commit_stage.sv
// Randomized bench for cpu_commit_stage against an arithmetic reference of the commit rules.
module tb_cpu_commit_stage;
  logic clock = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  cpu_commit_stage_if bus ();
  cpu_commit_stage dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rb;
    logic [31:0] rdata;
    logic        st;
    logic        byt;
    int          dly;
  } mem_op_t;

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] rb, input logic [4:0] rd,
                          input logic rw, input logic ld, input logic st, input logic byt);
    bus.in_valid      = 1'b1;
    bus.in_alu_result = alu;
    bus.in_rb_data    = rb;
    bus.in_reg_dest   = rd;
    bus.in_reg_write  = rw;
    bus.in_mem_read   = ld;
    bus.in_mem_write  = st;
    bus.in_mem_byte   = byt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_op(32'h0000_0400, 32'h5555_5555, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clock);
    n_run++;
    if ({bus.stall_out, bus.mem_req, bus.mem_we, bus.mem_be, bus.wb_valid, bus.wb_reg_write,
         bus.fw_commit_wb, bus.misalign} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", {bus.stall_out, bus.mem_req, bus.mem_we, bus.mem_be,
               bus.wb_valid, bus.wb_reg_write, bus.fw_commit_wb, bus.misalign});
    end
    n_run++;
    if ({bus.mem_addr, bus.mem_wdata, bus.wb_value, bus.wb_reg_dest, bus.fw_commit_value,
         bus.fw_commit_rd} !== 138'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h val=%h rd=%h fwv=%h fwrd=%h want all 0",
               bus.mem_addr, bus.mem_wdata, bus.wb_value, bus.wb_reg_dest, bus.fw_commit_value,
               bus.fw_commit_rd);
    end
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clock);
    drive_op(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.mem_ack = 1'b1;
    @(negedge clock);
    n_run++;
    if ({bus.wb_valid, bus.stall_out, bus.mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL alu_ctrl: got valid/stall/req=%b want 100", {bus.wb_valid, bus.stall_out, bus.mem_req});
    end
    n_run++;
    if ({bus.wb_value, bus.fw_commit_value, bus.fw_commit_rd, bus.fw_commit_wb, bus.wb_reg_write}
        !== {32'h1234, 32'h1234, 5'd5, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL alu_data: got val=%h fwv=%h fwrd=%0d fwwb=%b we=%b want 1234/1234/5/1/1",
               bus.wb_value, bus.fw_commit_value, bus.fw_commit_rd, bus.fw_commit_wb, bus.wb_reg_write);
    end
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    @(negedge clock);
    n_run++;
    if ({bus.wb_valid, bus.fw_commit_wb, bus.wb_value, bus.wb_reg_dest} !== {2'b00, 32'h1234, 5'd5}) begin
      n_fail++;
      $display("FAIL alu_hold: got valid=%b fwwb=%b val=%h rd=%0d want 0/0/1234/5",
               bus.wb_valid, bus.fw_commit_wb, bus.wb_value, bus.wb_reg_dest);
    end
  endtask

  task automatic test_mem_access();
    mem_op_t     ops[$];
    mem_op_t     op;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_addr, exp_wdata, exp_val;
    logic [3:0]  exp_be;
    logic        exp_mis;
    logic [72:0] act, exp;
    ops.push_back('{32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3});
    ops.push_back('{32'h0000_0203, 32'h0000_00A5, 32'h0, 1'b1, 1'b1, 2});
    ops.push_back('{32'h0000_0301, 32'h0, 32'h1122_3344, 1'b0, 1'b1, 1});
    ops.push_back('{32'h0000_0102, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 1});
    for (int n = 0; n < 14; n++) begin
      op.addr  = $urandom;
      op.rb    = $urandom;
      op.rdata = $urandom;
      op.st    = 1'($urandom_range(0, 1));
      op.byt   = 1'($urandom_range(0, 1));
      op.dly   = $urandom_range(1, 4);
      ops.push_back(op);
    end
    foreach (ops[k]) begin
      op        = ops[k];
      rd        = 5'($urandom_range(1, 31));
      rw        = 1'($urandom_range(0, 1));
      exp_addr  = op.addr - (op.addr % 4);
      exp_be    = op.byt ? 4'(1 << (op.addr % 4)) : 4'hF;
      exp_wdata = op.byt ? {24'h0, op.rb[7:0]} * 32'h0101_0101 : op.rb;
      exp_mis   = !op.byt && ((op.addr % 4) != 0);
      exp_val   = op.st ? op.addr
                : (op.byt ? (op.rdata >> (8 * (op.addr % 4))) & 32'hFF : op.rdata);
      @(negedge clock);
      drive_op(op.addr, op.rb, rd, rw, op.st ? 1'($urandom_range(0, 1)) : 1'b1, op.st, op.byt);
      for (int i = 1; i <= op.dly; i++) begin
        @(negedge clock);
        // A different op offered during the stall must not be taken.
        drive_op($urandom, $urandom, 5'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        act = {bus.mem_req, bus.stall_out, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
               bus.wb_valid, bus.misalign};
        exp = {1'b1, 1'b1, op.st, exp_be, exp_addr, exp_wdata, 1'b0, (i == 1) && exp_mis};
        n_run++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL mem_wait op%0d cyc%0d: got %h want %h", k, i, act, exp);
        end
        bus.mem_ack   = (i == op.dly);
        bus.mem_rdata = (i == op.dly) ? op.rdata : $urandom;
      end
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.mem_ack  = 1'b0;
      n_run++;
      if ({bus.mem_req, bus.stall_out, bus.wb_valid} !== 3'b001) begin
        n_fail++;
        $display("FAIL mem_done op%0d: got req/stall/valid=%b want 001", k,
                 {bus.mem_req, bus.stall_out, bus.wb_valid});
      end
      n_run++;
      if ({bus.wb_value, bus.wb_reg_dest, bus.wb_reg_write, bus.fw_commit_wb, bus.fw_commit_value}
          !== {exp_val, rd, !op.st && rw, !op.st && rw, exp_val}) begin
        n_fail++;
        $display("FAIL mem_result op%0d: got val=%h rd=%0d we=%b fwwb=%b want val=%h rd=%0d we=%b",
                 k, bus.wb_value, bus.wb_reg_dest, bus.wb_reg_write, bus.fw_commit_wb,
                 exp_val, rd, !op.st && rw);
      end
      @(negedge clock);
      n_run++;
      if ({bus.wb_valid, bus.mem_req} !== 2'b00) begin
        n_fail++;
        $display("FAIL mem_pulse op%0d: got valid/req=%b want 00", k, {bus.wb_valid, bus.mem_req});
      end
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clock);
    drive_op(32'h0000_0400, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    n_run++;
    if ({bus.mem_req, bus.stall_out} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstwait_pre: got req/stall=%b want 11", {bus.mem_req, bus.stall_out});
    end
    reset = 1'b1;
    @(negedge clock);
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    n_run++;
    if ({bus.mem_req, bus.stall_out, bus.wb_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstwait_drop: got req/stall/valid=%b want 000", {bus.mem_req, bus.stall_out, bus.wb_valid});
    end
    @(negedge clock);
    bus.mem_ack = 1'b0;
    n_run++;
    if ({bus.mem_req, bus.stall_out, bus.wb_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstwait_lateack: got req/stall/valid=%b want 000", {bus.mem_req, bus.stall_out, bus.wb_valid});
    end
    drive_op(32'h0000_ABCD, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    n_run++;
    if ({bus.wb_valid, bus.wb_value, bus.fw_commit_rd} !== {1'b1, 32'hABCD, 5'd7}) begin
      n_fail++;
      $display("FAIL rstwait_next: got valid=%b val=%h rd=%0d want 1/abcd/7",
               bus.wb_valid, bus.wb_value, bus.fw_commit_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic        v, prev_v;
    logic [31:0] val, prev_val, last_val;
    logic [4:0]  rd, prev_rd, last_rd;
    logic        rw, prev_rw;
    prev_v = 1'b0; prev_val = '0; prev_rd = '0; prev_rw = 1'b0;
    last_val = '0; last_rd = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (i > 0) begin
        n_run++;
        if ({bus.stall_out, bus.wb_valid} !== {1'b0, prev_v}) begin
          n_fail++;
          $display("FAIL b2b_valid cyc%0d: got stall/valid=%b want 0%b", i, {bus.stall_out, bus.wb_valid}, prev_v);
        end
        n_run++;
        if (prev_v) begin
          if ({bus.wb_value, bus.wb_reg_dest, bus.fw_commit_wb} !== {prev_val, prev_rd, prev_rw}) begin
            n_fail++;
            $display("FAIL b2b_data cyc%0d: got val=%h rd=%0d fwwb=%b want %h/%0d/%b", i,
                     bus.wb_value, bus.wb_reg_dest, bus.fw_commit_wb, prev_val, prev_rd, prev_rw);
          end
        end else if ({bus.wb_value, bus.wb_reg_dest, bus.fw_commit_wb} !== {last_val, last_rd, 1'b0}) begin
          n_fail++;
          $display("FAIL b2b_hold cyc%0d: got val=%h rd=%0d fwwb=%b want %h/%0d/0", i,
                   bus.wb_value, bus.wb_reg_dest, bus.fw_commit_wb, last_val, last_rd);
        end
      end
      if (prev_v) begin
        last_val = prev_val;
        last_rd  = prev_rd;
      end
      v   = (i == 0) || ($urandom_range(0, 3) != 0);
      val = $urandom;
      rd  = 5'($urandom);
      rw  = 1'($urandom_range(0, 1));
      drive_op(val, $urandom, rd, rw, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      bus.in_valid = v;
      bus.mem_ack  = 1'($urandom_range(0, 1));
      prev_v = v; prev_val = val; prev_rd = rd; prev_rw = rw;
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_alu_result = '0;
    bus.in_rb_data    = '0;
    bus.in_reg_dest   = '0;
    bus.in_reg_write  = 1'b0;
    bus.in_mem_read   = 1'b0;
    bus.in_mem_write  = 1'b0;
    bus.in_mem_byte   = 1'b0;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = '0;
    test_reset();
    test_alu();
    test_mem_access();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
